// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory; data has priority, fetch wins after MAX_FETCH_WAIT losses.
// Grant-to-ready >= 2 cycles; requests are held on mem_* until mem_ack, requesters stall via level req.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_ready,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_ready,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_f,
    output logic            stall_m
);
    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [CW-1:0] MAXW = CW'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            discard_q, discard_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            if_ready_q, if_ready_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            d_ready_q, d_ready_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

    logic if_elig, d_elig, grant_d, grant_i, ack_i, ack_d;

    // A requester whose ready is high this cycle is still holding the completed request.
    assign if_elig = if_req & ~if_ready_q;
    assign d_elig  = d_req & ~d_ready_q;
    assign grant_d = (state_q == IDLE) & d_elig & ((wait_cnt_q < MAXW) | ~if_elig);
    assign grant_i = (state_q == IDLE) & ~grant_d & if_elig;
    assign ack_i   = (state_q == BUSY_I) & mem_ack;
    assign ack_d   = (state_q == BUSY_D) & mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        discard_d   = 1'b0;

        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_we ? d_wstrb : '0;
            if (if_elig && (wait_cnt_q != MAXW)) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end

        if (grant_i) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            wait_cnt_d  = '0;
        end

        if (ack_d) begin
            mem_req_d = 1'b0;
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
        end

        // A flush seen during the fetch or on its ack edge drops the returning word.
        if (ack_i) begin
            mem_req_d = 1'b0;
            if (!(discard_q || if_flush)) begin
                if_rdata_d = mem_rdata;
                if_ready_d = 1'b1;
            end
        end

        if ((state_q == BUSY_I) && !mem_ack) begin
            discard_d = discard_q | if_flush;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign stall_f   = if_req & ~if_ready_q;
    assign stall_m   = d_req & ~d_ready_q;
endmodule
